// File: rtl/ysyx_24110015_ctrl_fsm_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_24110015_ctrl_fsm_pkg
//   Shared definitions for the NPC multi-cycle control unit:
//     - RV32 major opcode constants used to classify the latched instruction
//     - the control FSM state type
//     - opcode classification helpers and the wait-timer width helper
//   No ports (package).
// ----------------------------------------------------------------------------
package ysyx_24110015_ctrl_fsm_pkg;

    // RV32I major opcodes (instruction bits [6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_ALU_I  = 7'b0010011;
    localparam logic [6:0] OP_ALU_R  = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Control FSM states; HALT and ERR are absorbing until reset
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_ERR    = 3'd7
    } ctrl_state_e;

    // Opcodes this core can execute. SYSTEM is deliberately absent: the only
    // supported system instruction is ebreak, which the decoder flags separately
    // and which is handled before the legality check.
    function automatic logic isLegalOpcode(input logic [6:0] op);
        logic legal;
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_ALU_I, OP_ALU_R: legal = 1'b1;
            default:                               legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Instructions that need a data-memory access before writeback
    function automatic logic isMemOpcode(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    // Branches and stores have no destination register
    function automatic logic writesRegfile(input logic [6:0] op);
        return (op != OP_BRANCH) && (op != OP_STORE);
    endfunction

    // Wait-timer counter width: enough to hold the timeout, never below 8 bits
    function automatic int timerWidth(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 8) ? 8 : w;
    endfunction

endpackage

// File: rtl/ysyx_24110015_ctrl_fsm_if.sv
// ----------------------------------------------------------------------------
// ysyx_24110015_ctrl_fsm_if
//   Groups the control unit's handshake and strobe signals.
//   master : the control FSM (drives requests/enables, sees decoder + responses)
//   slave  : the datapath/memory side (drives decoder info + responses)
//   Signals:
//     opcode[6:0]  decoder opcode field of the latched instruction
//     ebreak       decoder: latched instruction is ebreak
//     ifuRvalid    instruction fetch response valid
//     lsuRvalid    load/store response valid
//     ifuReq       fetch request, level, held until ifuRvalid
//     irWe         latch fetched instruction into IR
//     lsuReq       memory request, level, held until lsuRvalid
//     lsuWen       memory request is a store
//     rfWen        register file write enable (1-cycle pulse)
//     pcWe         PC update enable (1-cycle pulse)
// ----------------------------------------------------------------------------
interface ysyx_24110015_ctrl_fsm_if;

    logic [6:0] opcode;
    logic       ebreak;
    logic       ifuRvalid;
    logic       lsuRvalid;
    logic       ifuReq;
    logic       irWe;
    logic       lsuReq;
    logic       lsuWen;
    logic       rfWen;
    logic       pcWe;

    modport master (
        input  opcode, ebreak, ifuRvalid, lsuRvalid,
        output ifuReq, irWe, lsuReq, lsuWen, rfWen, pcWe
    );

    modport slave (
        output opcode, ebreak, ifuRvalid, lsuRvalid,
        input  ifuReq, irWe, lsuReq, lsuWen, rfWen, pcWe
    );

endinterface

// File: rtl/ysyx_24110015_wait_timer.sv
// ----------------------------------------------------------------------------
// ysyx_24110015_wait_timer
//   Counts cycles spent waiting for a memory response and flags when the
//   current waiting cycle is the last one allowed.
//   Ports:
//     clk        in   core clock, rising edge
//     rst        in   asynchronous active-high reset
//     i_clear    in   restart the count (held while not waiting)
//     i_enable   in   one more waiting cycle without a response
//     o_expired  out  this is waiting cycle number TIMEOUT
// ----------------------------------------------------------------------------
module ysyx_24110015_wait_timer
    import ysyx_24110015_ctrl_fsm_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int WIDTH   = timerWidth(TIMEOUT)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    // r_count holds the number of waiting cycles already elapsed, so the
    // TIMEOUT-th waiting cycle sees TIMEOUT-1. Flagging expiry there lets the
    // FSM still prefer a response arriving in that very cycle.
    localparam logic [WIDTH-1:0] LAST = WIDTH'(TIMEOUT - 1);

    logic [WIDTH-1:0] r_count;

    // Counter saturates at LAST; the FSM leaves the waiting state before then
    // anyway, saturation just keeps a stuck state from wrapping the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LAST)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_expired = (r_count == LAST);

endmodule

// File: rtl/ysyx_24110015_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// ysyx_24110015_ctrl_fsm
//   Multi-cycle control unit of the NPC core. Steps every instruction through
//   FETCH, DECODE, EXEC, (MEM), WB, runs the IFU/LSU request/response
//   handshakes, gates IR/regfile/PC writes, and keeps halt/error status plus
//   cycle and retired-instruction counters.
//   Ports:
//     clk            in   core clock, rising edge
//     rst            in   asynchronous active-high reset
//     ctrl           if   handshake/strobe bundle (master side)
//     o_halted       out  sticky, set by ebreak
//     o_err          out  sticky, set by illegal opcode or response timeout
//     o_cycle_cnt    out  cycles since reset while not halted/err
//     o_instret_cnt  out  retired instruction count
// ----------------------------------------------------------------------------
module ysyx_24110015_ctrl_fsm
    import ysyx_24110015_ctrl_fsm_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    ysyx_24110015_ctrl_fsm_if.master ctrl,
    output logic                    o_halted,
    output logic                    o_err,
    output logic [CNT_W-1:0]        o_cycle_cnt,
    output logic [CNT_W-1:0]        o_instret_cnt
);

    localparam int TIMER_W = timerWidth(MEM_TIMEOUT);

    ctrl_state_e      r_state;
    ctrl_state_e      w_nextState;
    logic             w_timerClear;
    logic             w_timerEnable;
    logic             w_timerExpired;
    logic [CNT_W-1:0] r_cycleCnt;
    logic [CNT_W-1:0] r_instretCnt;

    // The timer runs only in the two waiting states. Every state that can
    // precede FETCH or MEM holds it cleared, so it starts at zero on entry.
    assign w_timerClear  = (r_state != ST_FETCH) && (r_state != ST_MEM);
    assign w_timerEnable = ((r_state == ST_FETCH) && !ctrl.ifuRvalid) ||
                           ((r_state == ST_MEM)   && !ctrl.lsuRvalid);

    ysyx_24110015_wait_timer #(
        .TIMEOUT (MEM_TIMEOUT),
        .WIDTH   (TIMER_W)
    ) u_waitTimer (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_timerClear),
        .i_enable  (w_timerEnable),
        .o_expired (w_timerExpired)
    );

    // State register. Reset forces IDLE immediately, which in turn forces
    // every state-decoded output low and drops any outstanding request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. In the waiting states a response always beats the
    // timeout. EXEC checks ebreak before legality because ebreak shares the
    // SYSTEM opcode, which is otherwise unsupported.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:   w_nextState = ST_FETCH;
            ST_FETCH: begin
                if (ctrl.ifuRvalid) begin
                    w_nextState = ST_DECODE;
                end else if (w_timerExpired) begin
                    w_nextState = ST_ERR;
                end
            end
            ST_DECODE: w_nextState = ST_EXEC;
            ST_EXEC: begin
                if (ctrl.ebreak) begin
                    w_nextState = ST_HALT;
                end else if (!isLegalOpcode(ctrl.opcode)) begin
                    w_nextState = ST_ERR;
                end else if (isMemOpcode(ctrl.opcode)) begin
                    w_nextState = ST_MEM;
                end else begin
                    w_nextState = ST_WB;
                end
            end
            ST_MEM: begin
                if (ctrl.lsuRvalid) begin
                    w_nextState = ST_WB;
                end else if (w_timerExpired) begin
                    w_nextState = ST_ERR;
                end
            end
            ST_WB:     w_nextState = ST_FETCH;
            ST_HALT:   w_nextState = ST_HALT;
            ST_ERR:    w_nextState = ST_ERR;
            default:   w_nextState = ST_ERR;
        endcase
    end

    // Output decode. Everything is a function of the state except irWe,
    // which must coincide with the accepted fetch response, and the store
    // and regfile qualifiers, which look at the latched opcode.
    always_comb begin
        ctrl.ifuReq = 1'b0;
        ctrl.irWe   = 1'b0;
        ctrl.lsuReq = 1'b0;
        ctrl.lsuWen = 1'b0;
        ctrl.rfWen  = 1'b0;
        ctrl.pcWe   = 1'b0;
        o_halted    = 1'b0;
        o_err       = 1'b0;
        case (r_state)
            ST_FETCH: begin
                ctrl.ifuReq = 1'b1;
                ctrl.irWe   = ctrl.ifuRvalid;
            end
            ST_MEM: begin
                ctrl.lsuReq = 1'b1;
                ctrl.lsuWen = (ctrl.opcode == OP_STORE);
            end
            ST_WB: begin
                ctrl.pcWe  = 1'b1;
                ctrl.rfWen = writesRegfile(ctrl.opcode);
            end
            ST_HALT:  o_halted = 1'b1;
            ST_ERR:   o_err    = 1'b1;
            default: ;
        endcase
    end

    // Performance counters, both wrapping. cycle_cnt stops once the core
    // halts or faults. An instruction retires when it leaves WB; ebreak
    // retires on its way into HALT so the count is already final there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycleCnt   <= '0;
            r_instretCnt <= '0;
        end else begin
            if ((r_state != ST_HALT) && (r_state != ST_ERR)) begin
                r_cycleCnt <= r_cycleCnt + CNT_W'(1);
            end
            if ((r_state == ST_WB) || ((r_state == ST_EXEC) && ctrl.ebreak)) begin
                r_instretCnt <= r_instretCnt + CNT_W'(1);
            end
        end
    end

    assign o_cycle_cnt   = r_cycleCnt;
    assign o_instret_cnt = r_instretCnt;

endmodule

// File: tb/tb_ysyx_24110015_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// tb_ysyx_24110015_ctrl_fsm
//   Self-checking bench for the NPC control unit. Instruction programs are
//   expanded into a per-cycle timeline of expected outputs from the
//   instruction-level rules (fetch latency, decode, exec, optional memory
//   phase, writeback, terminal halt/error), then replayed cycle by cycle.
// ----------------------------------------------------------------------------
module tb_ysyx_24110015_ctrl_fsm;

    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 255;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] ALU_I  = 7'b0010011;
    localparam logic [6:0] ALU_R  = 7'b0110011;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    logic             clk;
    logic             rst;
    logic             halted;
    logic             err;
    logic [CNT_W-1:0] cycleCnt;
    logic [CNT_W-1:0] instretCnt;

    ysyx_24110015_ctrl_fsm_if bus ();

    ysyx_24110015_ctrl_fsm #(
        .MEM_TIMEOUT (TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ctrl          (bus),
        .o_halted      (halted),
        .o_err         (err),
        .o_cycle_cnt   (cycleCnt),
        .o_instret_cnt (instretCnt)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One cycle of the expected timeline: inputs to drive plus outputs required
    typedef struct packed {
        logic        ifuRv;
        logic        lsuRv;
        logic [6:0]  op;
        logic        ebrk;
        logic        ifuReq;
        logic        irWe;
        logic        lsuReq;
        logic        lsuWen;
        logic        rfWen;
        logic        pcWe;
        logic        halted;
        logic        err;
        logic [31:0] cyc;
        logic [31:0] inst;
    } cycle_t;

    cycle_t      q[$];
    logic [31:0] mCyc;
    logic [31:0] mInst;
    int          checks;
    int          errors;
    logic [6:0]  legalOps [9];

    // A cycle with nothing requested; both response lines carry random noise
    // that the DUT must ignore because no request is pending.
    function automatic cycle_t blank(input logic [6:0] op, input logic ebrk);
        cycle_t e;
        e       = '0;
        e.op    = op;
        e.ebrk  = ebrk;
        e.ifuRv = 1'($urandom_range(0, 1));
        e.lsuRv = 1'($urandom_range(0, 1));
        return e;
    endfunction

    // Append a cycle; cycle_cnt advances after every cycle that is not halted/err
    task automatic pushCycle(input cycle_t e);
        e.cyc  = mCyc;
        e.inst = mInst;
        q.push_back(e);
        if (!e.halted && !e.err) mCyc = mCyc + 32'd1;
    endtask

    task automatic modelReset();
        q.delete();
        mCyc  = '0;
        mInst = '0;
        pushCycle(blank(7'd0, 1'b0));
    endtask

    task automatic pushTerminal(input logic isHalt, input logic [6:0] op, input logic ebrk);
        cycle_t e;
        repeat (6) begin
            e        = blank(op, ebrk);
            e.halted = isHalt;
            e.err    = !isHalt;
            pushCycle(e);
        end
    endtask

    // Expand one instruction. A latency >= TIMEOUT means the response never comes.
    task automatic appendInstr(input logic [6:0] op, input logic ebrk,
                               input int fetchLat, input int memLat);
        cycle_t e;
        logic   legal;
        int     n;
        n = (fetchLat >= TIMEOUT) ? TIMEOUT : fetchLat + 1;
        for (int i = 0; i < n; i++) begin
            e        = blank(op, ebrk);
            e.ifuReq = 1'b1;
            e.ifuRv  = (i == fetchLat);
            e.irWe   = e.ifuRv;
            pushCycle(e);
        end
        if (fetchLat >= TIMEOUT) begin
            pushTerminal(1'b0, op, ebrk);
            return;
        end
        pushCycle(blank(op, ebrk));
        pushCycle(blank(op, ebrk));
        if (ebrk) begin
            mInst = mInst + 32'd1;
            pushTerminal(1'b1, op, ebrk);
            return;
        end
        legal = 1'b0;
        foreach (legalOps[k]) if (legalOps[k] == op) legal = 1'b1;
        if (!legal) begin
            pushTerminal(1'b0, op, ebrk);
            return;
        end
        if (op == LOAD || op == STORE) begin
            n = (memLat >= TIMEOUT) ? TIMEOUT : memLat + 1;
            for (int i = 0; i < n; i++) begin
                e        = blank(op, ebrk);
                e.lsuReq = 1'b1;
                e.lsuWen = (op == STORE);
                e.lsuRv  = (i == memLat);
                pushCycle(e);
            end
            if (memLat >= TIMEOUT) begin
                pushTerminal(1'b0, op, ebrk);
                return;
            end
        end
        e       = blank(op, ebrk);
        e.pcWe  = 1'b1;
        e.rfWen = !(op == BRANCH || op == STORE);
        pushCycle(e);
        mInst = mInst + 32'd1;
    endtask

    task automatic applyStimulus(input cycle_t e);
        bus.ifuRvalid = e.ifuRv;
        bus.lsuRvalid = e.lsuRv;
        bus.opcode    = e.op;
        bus.ebreak    = e.ebrk;
    endtask

    task automatic checkOutput(input string tag, input int idx,
                               input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s cycle %0d: observed %0h expected %0h", tag, idx, observed, expected);
        end
    endtask

    task automatic checkCycle(input cycle_t e, input int idx);
        checkOutput("ifuReq",  idx, 32'(bus.ifuReq), 32'(e.ifuReq));
        checkOutput("irWe",    idx, 32'(bus.irWe),   32'(e.irWe));
        checkOutput("lsuReq",  idx, 32'(bus.lsuReq), 32'(e.lsuReq));
        checkOutput("lsuWen",  idx, 32'(bus.lsuWen), 32'(e.lsuWen));
        checkOutput("rfWen",   idx, 32'(bus.rfWen),  32'(e.rfWen));
        checkOutput("pcWe",    idx, 32'(bus.pcWe),   32'(e.pcWe));
        checkOutput("halted",  idx, 32'(halted),     32'(e.halted));
        checkOutput("err",     idx, 32'(err),        32'(e.err));
        checkOutput("cycle",   idx, cycleCnt,        e.cyc);
        checkOutput("instret", idx, instretCnt,      e.inst);
    endtask

    task automatic checkZeros(input string tag);
        cycle_t z;
        z = '0;
        checkOutput({tag, ".ifuReq"}, 0, 32'(bus.ifuReq), 32'(z.ifuReq));
        checkOutput({tag, ".lsuReq"}, 0, 32'(bus.lsuReq), 32'(z.lsuReq));
        checkOutput({tag, ".rfWen"},  0, 32'(bus.rfWen),  32'(z.rfWen));
        checkOutput({tag, ".pcWe"},   0, 32'(bus.pcWe),   32'(z.pcWe));
        checkOutput({tag, ".irWe"},   0, 32'(bus.irWe),   32'(z.irWe));
        checkOutput({tag, ".lsuWen"}, 0, 32'(bus.lsuWen), 32'(z.lsuWen));
        checkOutput({tag, ".halted"}, 0, 32'(halted),     32'(z.halted));
        checkOutput({tag, ".err"},    0, 32'(err),        32'(z.err));
        checkOutput({tag, ".cycle"},  0, cycleCnt,        z.cyc);
        checkOutput({tag, ".instret"},0, instretCnt,      z.inst);
    endtask

    // Asserting rst must clear everything within the same cycle
    task automatic doReset();
        rst = 1'b1;
        #1;
        checkZeros("reset");
        bus.ifuRvalid = 1'b0;
        bus.lsuRvalid = 1'b0;
        bus.opcode    = 7'd0;
        bus.ebreak    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
    endtask

    // Replay the timeline: drive just after the rising edge, check at the falling edge
    task automatic runQueue(input int upto);
        for (int i = 0; i < upto && i < q.size(); i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            applyStimulus(q[i]);
            @(negedge clk);
            checkCycle(q[i], i);
        end
    endtask

    initial begin
        cycle_t t;
        logic [6:0] op;
        checks   = 0;
        errors   = 0;
        legalOps = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, ALU_I, ALU_R};
        rst      = 1'b1;
        bus.ifuRvalid = 1'b0;
        bus.lsuRvalid = 1'b0;
        bus.opcode    = 7'd0;
        bus.ebreak    = 1'b0;

        // Directed instructions, a random mix, then ebreak into HALT
        doReset();
        appendInstr(ALU_I, 1'b0, 2, 0);
        appendInstr(LOAD, 1'b0, 1, 3);
        appendInstr(STORE, 1'b0, 0, 2);
        appendInstr(BRANCH, 1'b0, 1, 0);
        for (int i = 0; i < 24; i++) begin
            op = legalOps[$urandom_range(0, 8)];
            appendInstr(op, 1'b0, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
        end
        appendInstr(SYSTEM, 1'b1, 1, 0);
        runQueue(q.size());

        // Illegal opcode 0000000 after one good instruction
        doReset();
        appendInstr(ALU_R, 1'b0, 0, 0);
        appendInstr(7'b0000000, 1'b0, 1, 0);
        runQueue(q.size());

        // SYSTEM opcode that is not ebreak is illegal
        doReset();
        appendInstr(SYSTEM, 1'b0, 0, 0);
        runQueue(q.size());

        // Fetch response on the last allowed cycle, then a fetch that never answers
        doReset();
        appendInstr(ALU_I, 1'b0, TIMEOUT - 1, 0);
        appendInstr(LUI, 1'b0, TIMEOUT, 0);
        runQueue(q.size());

        // Same two boundaries on the memory side
        doReset();
        appendInstr(STORE, 1'b0, 0, TIMEOUT - 1);
        appendInstr(LOAD, 1'b0, 0, TIMEOUT);
        runQueue(q.size());

        // Reset in the third MEM cycle of a load, then a stale lsuRvalid
        doReset();
        appendInstr(LOAD, 1'b0, 0, 10);
        runQueue(7);
        doReset();
        appendInstr(ALU_R, 1'b0, 1, 0);
        appendInstr(JAL, 1'b0, 0, 0);
        t = q[0]; t.lsuRv = 1'b1; q[0] = t;
        t = q[1]; t.lsuRv = 1'b1; q[1] = t;
        t = q[2]; t.lsuRv = 1'b1; q[2] = t;
        runQueue(q.size());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
